// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2 - single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count, synchronous flush
// and sticky overflow/underflow flags.
//
// Parameters:
//   WIDTH  data word width (>= 1)
//   DEPTH  number of entries, power of two (>= 2)
//   FWFT   0 = registered read, 1 = first-word-fall-through
//   CW     width of count/threshold fields, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   flush            synchronous clear of pointers and count
//   wr_en, wr_data   write request and data
//   rd_en, rd_data   read request (pop in FWFT mode) and read data
//   af_level         almost-full threshold  (almost_full  = count >= af_level)
//   ae_level         almost-empty threshold (almost_empty = count <= ae_level)
//   err_clr          clears overflow, underflow and max_level
//   count            occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   status flags from the registered count
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
//   max_level        high-water mark of count
//
// Build option: define SYNC_FIFO_HWM_EN to build the high-water-mark tracker; otherwise
// max_level is tied to 0.

module sync_fifo_v2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned FWFT  = 0,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic [CW-1:0]    af_level,
  input  logic [CW-1:0]    ae_level,
  input  logic             err_clr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    max_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one wrap bit above the address; wrap is plain modulo arithmetic.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_acc, rd_acc, wr_store;

  assign full   = (count_q == CntFull);
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  // Flush and reset suppress the memory write so the dropped word is never stored.
  assign wr_store = wr_acc && !flush && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  assign overflow_d  = (overflow_q && !err_clr) || (wr_en && full && !flush);
  assign underflow_d = (underflow_q && !err_clr) || (rd_en && empty && !flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_store) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; forced to 0 while empty so reset shows 0.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q <= '0;
      end else if (rd_acc && !flush) begin
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
    assign rd_data = rd_data_q;
  end

`ifdef SYNC_FIFO_HWM_EN
  logic [CW-1:0] max_level_q;
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      max_level_q <= '0;
    end else if (count_q > max_level_q) begin
      max_level_q <= count_q;
    end
  end
  assign max_level = max_level_q;
`else
  assign max_level = '0;
`endif

  assign count        = count_q;
  assign almost_full  = (count_q >= af_level);
  assign almost_empty = (count_q <= ae_level);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
module tb_sync_fifo_v2;

`ifdef SYNC_FIFO_HWM_EN
  localparam bit HwmEn = 1'b1;
`else
  localparam bit HwmEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush, wr_en, rd_en, err_clr;
  logic [7:0] wr_data, rd_data;
  logic [3:0] af_level, ae_level, count, max_level;
  logic full, empty, almost_full, almost_empty, overflow, underflow;

  logic f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic [3:0] f_count, f_max_level;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .af_level(af_level), .ae_level(ae_level),
    .err_clr(err_clr), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .max_level(max_level)
  );

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(1'b0), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .af_level(af_level), .ae_level(ae_level),
    .err_clr(1'b0), .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf),
    .underflow(f_udf), .max_level(f_max_level)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_data = '0; af_level = 4'd6; ae_level = 4'd2;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);

    // Fill 0x01..0x08, thresholds af=6 ae=2
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick;
      chk("fill_count", 32'(count), i);
      chk("fill_af", 32'(almost_full), 32'(i >= 6));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf0", 32'(overflow), 0);
    wr_data = 8'h09;
    tick;
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);

    // Drain: rd_data follows one cycle after each rd_en
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick;
      chk("drain_data", 32'(rd_data), i);
      chk("drain_count", 32'(count), 8 - i);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("udf_before", 32'(underflow), 0);
    tick;
    rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 1);
    chk("udf_hold_data", 32'(rd_data), 8'h08);

    // err_clr with a concurrent new error: set wins
    err_clr = 1'b1; rd_en = 1'b1;
    tick;
    chk("clr_setwins_udf", 32'(underflow), 1);
    chk("clr_ovf", 32'(overflow), 0);
    rd_en = 1'b0;
    tick;
    err_clr = 1'b0;
    chk("clr_udf", 32'(underflow), 0);

    // Simultaneous access at count=4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick;
    end
    chk("sim_pre_count", 32'(count), 4);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h14 + 8'(i);
      tick;
      chk("sim_data", 32'(rd_data), 8'h10 + 8'(i));
      chk("sim_count", 32'(count), 4);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h17 + 8'(i);
      tick;
    end
    chk("sim_full", 32'(full), 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    tick;
    chk("simfull_count", 32'(count), 7);
    chk("simfull_ovf", 32'(overflow), 1);
    chk("simfull_data", 32'(rd_data), 8'h13);
    wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1;
      tick;
      chk("simdrain_data", 32'(rd_data), 8'h14 + 8'(i));
    end
    rd_en = 1'b0;
    chk("simdrain_empty", 32'(empty), 1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;

    // Flush at count=5 with concurrent wr_en/rd_en; underflow held set across it
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("fl_udf_pre", 32'(underflow), 1);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      tick;
    end
    chk("fl_pre_count", 32'(count), 5);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    tick;
    idle;
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_udf", 32'(underflow), 1);
    chk("fl_ovf", 32'(overflow), 0);
    chk("fl_rd_data", 32'(rd_data), 8'h1A);
    chk("fl_max", 32'(max_level), HwmEn ? 5 : 0);
    tick;
    chk("fl_count_hold", 32'(count), 0);
    wr_en = 1'b1; wr_data = 8'h30;
    tick;
    wr_en = 1'b0; rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("fl_after_data", 32'(rd_data), 8'h30);

    // Wrap-around: 6 writes, 20 concurrent cycles, 6 reads
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      tick;
      chk("wr_af", 32'(almost_full), 32'(i + 1 >= 6));
      chk("wr_ae", 32'(almost_empty), 32'(i + 1 <= 2));
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h46 + 8'(i);
      tick;
      chk("wrap_data", 32'(rd_data), 8'h40 + 8'(i));
      chk("wrap_count", 32'(count), 6);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_en = 1'b1;
      tick;
      chk("wrdrain_data", 32'(rd_data), 8'h54 + 8'(i));
      chk("wrdrain_af", 32'(almost_full), 32'(5 - i >= 6));
      chk("wrdrain_ae", 32'(almost_empty), 32'(5 - i <= 2));
    end
    rd_en = 1'b0;

    // Live threshold edge values
    af_level = 4'd0; ae_level = 4'd0;
    #1;
    chk("af0_empty", 32'(almost_full), 1);
    chk("ae0_empty", 32'(almost_empty), 1);
    wr_en = 1'b1; wr_data = 8'h5F;
    tick;
    wr_en = 1'b0;
    chk("ae0_one", 32'(almost_empty), 0);
    af_level = 4'd2;
    #1;
    chk("af2_one", 32'(almost_full), 0);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    af_level = 4'd6; ae_level = 4'd2;

    // High-water mark and mid-stream reset
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      tick;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick;
    end
    rd_en = 1'b0;
    chk("hwm_count", 32'(count), 3);
    chk("hwm_max", 32'(max_level), HwmEn ? 7 : 0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick;
    end
    rd_en = 1'b0;
    chk("hwm_udf", 32'(underflow), 1);
    chk("hwm_rd_data", 32'(rd_data), 8'h56);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
      tick;
    end
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick;
    reset = 1'b0; wr_en = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_rd_data", 32'(rd_data), 0);
    chk("mrst_max", 32'(max_level), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_udf", 32'(underflow), 0);
    wr_en = 1'b1; wr_data = 8'h55;
    tick;
    wr_en = 1'b0; rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("mrst_after_data", 32'(rd_data), 8'h55);

    // FWFT instance
    chk("fw_rst_empty", 32'(f_empty), 1);
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick;
    chk("fw_empty", 32'(f_empty), 0);
    chk("fw_first", 32'(f_rd_data), 8'hA5);
    f_wr_data = 8'h5A;
    tick;
    f_wr_en = 1'b0;
    chk("fw_hold", 32'(f_rd_data), 8'hA5);
    chk("fw_count2", 32'(f_count), 2);
    f_rd_en = 1'b1;
    tick;
    f_rd_en = 1'b0;
    chk("fw_next", 32'(f_rd_data), 8'h5A);
    chk("fw_count1", 32'(f_count), 1);
    f_rd_en = 1'b1;
    tick;
    f_rd_en = 1'b0;
    chk("fw_empty_end", 32'(f_empty), 1);
    chk("fw_udf", 32'(f_udf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
